// File: rtl/alu_seq_ctrl.sv
// Micro-step sequencer for a register-file ALU datapath: latches an instruction on
// start and walks the T2..T5 control steps, decoding bus strobes from state (Moore).
module alu_seq_ctrl #(
    parameter int NREG = 16,
    parameter int IR_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IR_W-1:0] ir,
    input  logic            stall,
    output logic [NREG-1:0] reg_out,
    output logic [NREG-1:0] reg_in,
    output logic            yin,
    output logic            zin,
    output logic            zlowout,
    output logic            zhighout,
    output logic            hiin,
    output logic            loin,
    output logic [12:0]     alu_op,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [2:0]      dbg_state
);

    // Handshake: start is taken only in IDLE with stall low; while busy is high start
    // is ignored; done (with illegal for rejects) pulses for one cycle at completion.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_FIN  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [3:0] rc_q, rc_d;

    logic [4:0] in_op;
    logic [3:0] in_ra, in_rb, in_rc;
    logic       in_bin, in_md, in_un, in_bad;
    logic       q_md, q_un;
    logic       unused_ir_bits;

    function automatic logic is_bin(input logic [4:0] op);
        return op <= 5'd8;
    endfunction

    function automatic logic is_md(input logic [4:0] op);
        return (op == 5'd9) || (op == 5'd10);
    endfunction

    function automatic logic is_un(input logic [4:0] op);
        return (op == 5'd11) || (op == 5'd12);
    endfunction

    function automatic logic reg_bad(input logic [3:0] r);
        return {28'd0, r} >= 32'(NREG);
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [3:0] r);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r == 4'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign unused_ir_bits = ^ir;

    assign in_op  = ir[31:27];
    assign in_ra  = ir[26:23];
    assign in_rb  = ir[22:19];
    assign in_rc  = ir[18:15];
    assign in_bin = is_bin(in_op);
    assign in_md  = is_md(in_op);
    assign in_un  = is_un(in_op);
    // Only the register fields an instruction class actually uses are range-checked.
    assign in_bad = !(in_bin || in_md || in_un)
                  || reg_bad(in_rb)
                  || ((in_bin || in_un) && reg_bad(in_ra))
                  || ((in_bin || in_md) && reg_bad(in_rc));

    assign q_md = is_md(op_q);
    assign q_un = is_un(op_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d = in_op;
                        ra_d = in_ra;
                        rb_d = in_rb;
                        rc_d = in_rc;
                        if (in_bad)     state_d = S_ERR;
                        else if (in_un) state_d = S_T3;
                        else            state_d = S_T2;
                    end
                end
                S_T2:    state_d = S_T3;
                S_T3:    state_d = S_T4;
                S_T4:    state_d = q_md ? S_T5 : S_FIN;
                S_T5:    state_d = S_FIN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // Reset and stall blank every strobe without disturbing the held step.
    always_comb begin
        reg_out  = '0;
        reg_in   = '0;
        yin      = 1'b0;
        zin      = 1'b0;
        zlowout  = 1'b0;
        zhighout = 1'b0;
        hiin     = 1'b0;
        loin     = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        illegal  = 1'b0;
        busy     = !reset && (state_q != S_IDLE);
        if (!reset && !stall) begin
            case (state_q)
                S_T2: begin
                    reg_out = onehot(rb_q);
                    yin     = 1'b1;
                end
                S_T3: begin
                    reg_out = q_un ? onehot(rb_q) : onehot(rc_q);
                    alu_op  = 13'd1 << op_q;
                    zin     = 1'b1;
                end
                S_T4: begin
                    zlowout = 1'b1;
                    if (q_md) loin = 1'b1;
                    else      reg_in = onehot(ra_q);
                end
                S_T5: begin
                    zhighout = 1'b1;
                    hiin     = 1'b1;
                end
                S_FIN: done = 1'b1;
                S_ERR: begin
                    done    = 1'b1;
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule
